// File: rtl/floo_ring_on_mesh_mcast_fork_pkg.sv
// Shared definitions for the ring-on-mesh multicast fork: output port
// indices, default route count and a popcount helper.
package floo_ring_on_mesh_mcast_fork_pkg;

  // Output port indices of a router input; Eject delivers to the local tile.
  typedef enum logic [2:0] {
    Eject = 3'd0,
    North = 3'd1,
    East  = 3'd2,
    South = 3'd3,
    West  = 3'd4
  } route_dir_e;

  localparam int unsigned NumMeshRoutes = 5;

  // Number of set bits in a (zero-extended) mask of up to 32 bits.
  function automatic logic [5:0] popcount(input logic [31:0] vec);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/floo_ring_on_mesh_mcast_fork.sv
// Multicast fork: replicates one flit to every output selected in a
// multi-hot route mask. Each output completes its own valid/ready handshake;
// the input is released once all selected outputs have taken their copy.
// The data path is purely combinational; sent_q remembers which outputs were
// already served for the flit currently presented.
// Optional build macro FLOO_MCAST_FORK_STATS_EN adds multicast and copy
// counters (mcast_cnt_o, copy_cnt_o).
module floo_ring_on_mesh_mcast_fork
  import floo_ring_on_mesh_mcast_fork_pkg::*;
#(
  parameter int unsigned NumRoutes = NumMeshRoutes,
  parameter type         flit_t    = logic,
  parameter bit          DropEmpty = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  flit_t                channel_i,
  input  logic [NumRoutes-1:0] route_sel_i,
  output logic [NumRoutes-1:0] valid_o,
  input  logic [NumRoutes-1:0] ready_i,
  output flit_t                channel_o [NumRoutes],
  output logic                 drop_o
`ifdef FLOO_MCAST_FORK_STATS_EN
  ,
  output logic [31:0]          mcast_cnt_o,
  output logic [31:0]          copy_cnt_o
`endif
);

  logic [NumRoutes-1:0] sent_q, sent_d;
  logic [NumRoutes-1:0] done;
  logic [NumRoutes-1:0] out_hs;
  logic                 mask_empty;
  logic                 in_hs;

  // Every output carries the same flit; only valid_o differs per port.
  for (genvar i = 0; i < NumRoutes; i++) begin : gen_channel
    assign channel_o[i] = channel_i;
  end

  // Handshake logic: present the flit to unserved selected outputs and
  // release the input once every selected output is served or ready now.
  always_comb begin
    valid_o    = '0;
    ready_o    = 1'b0;
    drop_o     = 1'b0;
    mask_empty = (route_sel_i == '0);
    done       = ~route_sel_i | sent_q | ready_i;
    if (!mask_empty) begin
      valid_o = {NumRoutes{valid_i}} & route_sel_i & ~sent_q;
      ready_o = valid_i & (&done);
    end else if (DropEmpty) begin
      ready_o = valid_i;
      drop_o  = valid_i;
    end
    out_hs = valid_o & ready_i;
    in_hs  = valid_i & ready_o;
    sent_d = in_hs ? '0 : (sent_q | out_hs);
  end

  // Served-output bookkeeping for the flit in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sent_q <= '0;
    end else begin
      sent_q <= sent_d;
    end
  end

`ifdef FLOO_MCAST_FORK_STATS_EN
  logic [31:0] mcast_cnt_q, mcast_cnt_d;
  logic [31:0] copy_cnt_q, copy_cnt_d;

  // Count accepted multicast flits and delivered copies; both wrap at 2^32.
  always_comb begin
    mcast_cnt_d = mcast_cnt_q;
    copy_cnt_d  = copy_cnt_q + 32'(popcount(32'(out_hs)));
    if (in_hs && (popcount(32'(route_sel_i)) > 6'd1)) begin
      mcast_cnt_d = mcast_cnt_q + 32'd1;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcast_cnt_q <= '0;
      copy_cnt_q  <= '0;
    end else begin
      mcast_cnt_q <= mcast_cnt_d;
      copy_cnt_q  <= copy_cnt_d;
    end
  end

  assign mcast_cnt_o = mcast_cnt_q;
  assign copy_cnt_o  = copy_cnt_q;
`endif

`ifndef TARGET_SYNTHESIS
  // A partially forked flit must stay presented and unchanged until released.
  a_valid_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (|sent_q) |-> valid_i);
  a_flit_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (|sent_q) |-> ($stable(channel_i) && $stable(route_sel_i)));
`endif

endmodule

// File: tb/tb_floo_ring_on_mesh_mcast_fork.sv
// Scoreboard bench for the multicast fork. Two instances share the stimulus:
// dut (drops empty masks) and dut_nd (stalls on empty masks).
module tb_floo_ring_on_mesh_mcast_fork;

  localparam int NR = 5;
  typedef logic [15:0] flit_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  flit_t         chan;
  logic [NR-1:0] sel;
  logic [NR-1:0] rdy;

  logic          rdy_o1, drop1, rdy_o0, drop0;
  logic [NR-1:0] vo1, vo0;
  flit_t         ch1 [NR];
  flit_t         ch0 [NR];
`ifdef FLOO_MCAST_FORK_STATS_EN
  logic [31:0]   mc1, cp1, mc0, cp0;
  logic [31:0]   mc_exp, cp_exp;
`endif

  int            checks = 0;
  int            errors = 0;
  flit_t         exp_q [NR][$];
  logic [NR-1:0] dlv;
  bit            acc;

  always #5 clk = ~clk;

  floo_ring_on_mesh_mcast_fork #(.NumRoutes(NR), .flit_t(flit_t), .DropEmpty(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(rdy_o1),
    .channel_i(chan), .route_sel_i(sel), .valid_o(vo1), .ready_i(rdy),
    .channel_o(ch1), .drop_o(drop1)
`ifdef FLOO_MCAST_FORK_STATS_EN
    , .mcast_cnt_o(mc1), .copy_cnt_o(cp1)
`endif
  );

  floo_ring_on_mesh_mcast_fork #(.NumRoutes(NR), .flit_t(flit_t), .DropEmpty(1'b0)) dut_nd (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(rdy_o0),
    .channel_i(chan), .route_sel_i(sel), .valid_o(vo0), .ready_i(rdy),
    .channel_o(ch0), .drop_o(drop0)
`ifdef FLOO_MCAST_FORK_STATS_EN
    , .mcast_cnt_o(mc0), .copy_cnt_o(cp0)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) exp_q[i].delete();
    dlv = '0;
    acc = 1'b0;
`ifdef FLOO_MCAST_FORK_STATS_EN
    mc_exp = '0;
    cp_exp = '0;
`endif
  endtask

  // Reference model: a flit is owed once to every selected output; the input
  // may only be released once every owed copy has been delivered.
  always @(negedge clk) begin : monitor
    logic [NR-1:0] ev, hs;
    logic          er;
    if (rst_n) begin
      ev = valid ? (sel & ~dlv) : '0;
      er = valid && ((sel == '0) ? 1'b1 : ((sel & ~dlv & ~rdy) == '0));
      chk("valid_o", 32'(vo1), 32'(ev));
      chk("ready_o", 32'(rdy_o1), 32'(er));
      chk("drop_o", 32'(drop1), 32'(valid && (sel == '0)));
      chk("nd_valid_o", 32'(vo0), 32'(ev));
      chk("nd_ready_o", 32'(rdy_o0), 32'((sel != '0) && er));
      chk("nd_drop_o", 32'(drop0), 32'd0);
`ifdef FLOO_MCAST_FORK_STATS_EN
      chk("mcast_cnt", mc1, mc_exp);
      chk("copy_cnt", cp1, cp_exp);
`endif
      hs = vo1 & rdy;
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dup_copy: port %0d got 0x%0h expected no copy", i, ch1[i]);
          end else begin
            chk("copy_data", 32'(ch1[i]), 32'(exp_q[i].pop_front()));
          end
        end
      end
`ifdef FLOO_MCAST_FORK_STATS_EN
      cp_exp = cp_exp + 32'($countones(hs));
      if (valid && rdy_o1 && ($countones(sel) > 1)) mc_exp = mc_exp + 32'd1;
`endif
      if (valid && rdy_o1) begin
        for (int i = 0; i < NR; i++) chk("lost_copy", 32'(exp_q[i].size()), 32'd0);
        dlv = '0;
        acc = 1'b1;
      end else begin
        dlv = dlv | hs;
      end
    end
  end

  // Waits for input acceptance; called #1 after a posedge with inputs set.
  task automatic wait_acc(input bit rnd, input logic [NR-1:0] r1, output int cyc);
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (acc) break;
      if (cyc >= 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no ready_o after %0d cycles expected acceptance", cyc);
        valid = 1'b0;
        rst_n = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        break;
      end
      rdy = rnd ? NR'($urandom) : r1;
    end
    acc   = 1'b0;
    valid = 1'b0;
  endtask

  task automatic send(input flit_t d, input logic [NR-1:0] m, input bit rnd,
                      input logic [NR-1:0] r0, input logic [NR-1:0] r1, output int cyc);
    for (int i = 0; i < NR; i++) if (m[i]) exp_q[i].push_back(d);
    acc   = 1'b0;
    valid = 1'b1;
    chan  = d;
    sel   = m;
    rdy   = rnd ? NR'($urandom) : r0;
    wait_acc(rnd, r1, cyc);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc;
    rst_n = 1'b0;
    valid = 1'b0;
    chan  = '0;
    sel   = '0;
    rdy   = '0;
    clear_model();
    #2;
    chk("rst_valid_o", 32'(vo1), 32'd0);
    chk("rst_ready_o", 32'(rdy_o1), 32'd0);
    chk("rst_drop_o", 32'(drop1), 32'd0);
`ifdef FLOO_MCAST_FORK_STATS_EN
    chk("rst_mcast_cnt", mc1, 32'd0);
    chk("rst_copy_cnt", cp1, 32'd0);
`endif
    valid = 1'b1;
    sel   = 5'b00110;
    #1;
    chk("rst_valid_eq", 32'(vo1), 32'h06);
    chk("rst_ready_eq", 32'(rdy_o1), 32'd0);
    valid = 1'b0;
    sel   = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send(16'h1111, 5'b00010, 1'b0, 5'b11111, 5'b11111, cyc);
    chk("unicast_cycles", 32'(cyc), 32'd1);
    send(16'h2222, 5'b00101, 1'b0, 5'b11111, 5'b11111, cyc);
    chk("mcast_cycles", 32'(cyc), 32'd1);
    send(16'h3333, 5'b01001, 1'b0, 5'b00001, 5'b01000, cyc);
    chk("stagger_cycles", 32'(cyc), 32'd2);
    send(16'h4444, 5'b00000, 1'b0, 5'b00000, 5'b00000, cyc);
    chk("drop_cycles", 32'(cyc), 32'd1);

    // Empty mask held: the dropping instance consumes every cycle, the
    // stalling instance never accepts.
    valid = 1'b1;
    sel   = '0;
    chan  = 16'h4545;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("nd_stall", 32'(rdy_o0), 32'd0);
    end
    valid = 1'b0;
    acc   = 1'b0;

    // Partial fork, then asynchronous reset in the middle of the cycle.
    for (int i = 0; i < 3; i++) exp_q[i].push_back(16'h5555);
    valid = 1'b1;
    chan  = 16'h5555;
    sel   = 5'b00111;
    rdy   = 5'b00100;
    @(posedge clk);
    #1;
    chk("partial_valid_o", 32'(vo1), 32'h03);
    rdy = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_o", 32'(vo1), 32'h07);
    chk("midrst_ready_o", 32'(rdy_o1), 32'd0);
    dlv = '0;
    exp_q[2].push_back(16'h5555);
`ifdef FLOO_MCAST_FORK_STATS_EN
    mc_exp = '0;
    cp_exp = '0;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc   = 1'b0;
    rdy   = 5'b11111;
    wait_acc(1'b0, 5'b11111, cyc);
    chk("refork_cycles", 32'(cyc), 32'd1);

    // Back-to-back burst with alternating masks and random ready.
    for (int k = 0; k < 8; k++) begin
      send(flit_t'($urandom), (k % 2 == 0) ? 5'b00011 : 5'b10001, 1'b1, '0, '0, cyc);
    end

    // Random flits with random masks, including empty ones.
    for (int k = 0; k < 60; k++) begin
      send(flit_t'($urandom), NR'($urandom_range(0, 31)), 1'b1, '0, '0, cyc);
    end

    rdy = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) chk("drained", 32'(exp_q[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
